// File: rtl/adder_frame_scheduler_if.sv
// Handshake bundle between two operand requesters, the frame scheduler and the result consumer.
interface adder_frame_scheduler_if #(
    parameter int unsigned ADDER_WIDTH = 14,
    parameter int unsigned LEVELS      = 3
);
    logic                          a_valid;
    logic                          a_ready;
    logic [ADDER_WIDTH-1:0]        a_data;
    logic                          a_last;
    logic                          b_valid;
    logic                          b_ready;
    logic [ADDER_WIDTH-1:0]        b_data;
    logic                          b_last;
    logic                          out_valid;
    logic                          out_ready;
    logic [ADDER_WIDTH+LEVELS-1:0] out_sum;
    logic                          out_src;
    logic [LEVELS:0]               out_count;

    modport master (
        output a_valid, a_data, a_last, b_valid, b_data, b_last, out_ready,
        input  a_ready, b_ready, out_valid, out_sum, out_src, out_count
    );

    modport slave (
        input  a_valid, a_data, a_last, b_valid, b_data, b_last, out_ready,
        output a_ready, b_ready, out_valid, out_sum, out_src, out_count
    );
endinterface

// File: rtl/adder_frame_scheduler.sv
// Round-robin frame scheduler sharing one accumulating adder between two requesters.
// Each granted frame is summed serially, one operand per cycle, up to 2**LEVELS operands.
module adder_frame_scheduler #(
    parameter int unsigned ADDER_WIDTH = 14,
    parameter int unsigned LEVELS      = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    adder_frame_scheduler_if.slave  bus,
    output logic                    busy
);
    localparam int unsigned ACC_W = ADDER_WIDTH + LEVELS;
    localparam int unsigned CNT_W = LEVELS + 1;
    localparam int unsigned N     = 1 << LEVELS;

    typedef enum logic [1:0] {S_IDLE, S_ARB, S_ACCUM, S_HOLD} state_e;

    state_e             state_q, state_d;
    logic               grant_q, grant_d;
    logic               last_src_q, last_src_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   out_sum_q, out_sum_d;
    logic               out_src_q, out_src_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;
    logic               a_ready_q, a_ready_d;
    logic               b_ready_q, b_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;

    logic                   sel_valid;
    logic                   sel_last;
    logic                   sel_ready;
    logic [ADDER_WIDTH-1:0] sel_data;
    logic [ACC_W-1:0]       acc_sum;
    logic [CNT_W-1:0]       cnt_inc;

    // Datapath mux onto the shared adder, steered by the registered grant
    always_comb begin
        sel_valid = grant_q ? bus.b_valid : bus.a_valid;
        sel_last  = grant_q ? bus.b_last  : bus.a_last;
        sel_data  = grant_q ? bus.b_data  : bus.a_data;
        sel_ready = grant_q ? b_ready_q   : a_ready_q;
        acc_sum   = acc_q + ACC_W'(sel_data);
        cnt_inc   = cnt_q + CNT_W'(1);
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_src_d  = last_src_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_sum_d   = out_sum_q;
        out_src_d   = out_src_q;
        out_count_d = out_count_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.a_valid || bus.b_valid) state_d = S_ARB;
            end
            S_ARB: begin
                // On a tie the requester that did not own the previous frame wins
                if (bus.a_valid || bus.b_valid) begin
                    if (bus.a_valid && bus.b_valid) grant_d = ~last_src_q;
                    else                            grant_d = bus.b_valid;
                    last_src_d = grant_d;
                    acc_d      = '0;
                    cnt_d      = '0;
                    state_d    = S_ACCUM;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCUM: begin
                if (sel_valid && sel_ready) begin
                    acc_d = acc_sum;
                    cnt_d = cnt_inc;
                    // Close on last, or force-close once the frame holds N operands
                    if (sel_last || (cnt_inc == CNT_W'(N))) begin
                        out_sum_d   = acc_sum;
                        out_src_d   = grant_q;
                        out_count_d = cnt_inc;
                        state_d     = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        a_ready_d   = (state_d == S_ACCUM) && !grant_d;
        b_ready_d   = (state_d == S_ACCUM) &&  grant_d;
        out_valid_d = (state_d == S_HOLD);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            grant_q     <= 1'b0;
            last_src_q  <= 1'b1;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_sum_q   <= '0;
            out_src_q   <= 1'b0;
            out_count_q <= '0;
            a_ready_q   <= 1'b0;
            b_ready_q   <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_src_q  <= last_src_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_sum_q   <= out_sum_d;
            out_src_q   <= out_src_d;
            out_count_q <= out_count_d;
            a_ready_q   <= a_ready_d;
            b_ready_q   <= b_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.a_ready   = a_ready_q;
    assign bus.b_ready   = b_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_src   = out_src_q;
    assign bus.out_count = out_count_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_adder_frame_scheduler.sv
// Directed bench for adder_frame_scheduler: frame sums, truncation, arbitration, backpressure, reset.
module tb_adder_frame_scheduler;
    localparam int unsigned AW = 14;
    localparam int unsigned LV = 3;
    localparam int unsigned SW = AW + LV;
    localparam int unsigned CW = LV + 1;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    always #5 clk = ~clk;

    adder_frame_scheduler_if #(.ADDER_WIDTH(AW), .LEVELS(LV)) bus ();

    adder_frame_scheduler #(.ADDER_WIDTH(AW), .LEVELS(LV)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    typedef struct packed {
        logic          src;
        logic [SW-1:0] sum;
        logic [CW-1:0] cnt;
    } res_t;

    res_t rq[$];
    int   n_cmp    = 0;
    int   n_err    = 0;
    int   both_rdy = 0;

    // Capture every consumed result
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready)
            rq.push_back({bus.out_src, bus.out_sum, bus.out_count});
    end

    always @(negedge clk) begin
        if (bus.a_ready && bus.b_ready) both_rdy <= both_rdy + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one beat (caller is at a negedge); returns at the negedge after acceptance
    task automatic drive(input logic sel, input logic [AW-1:0] d, input logic l);
        int w = 0;
        if (sel) begin bus.b_valid = 1'b1; bus.b_data = d; bus.b_last = l; end
        else     begin bus.a_valid = 1'b1; bus.a_data = d; bus.a_last = l; end
        while (w < 300) begin
            if (sel ? bus.b_ready : bus.a_ready) begin
                @(posedge clk);
                break;
            end
            @(negedge clk);
            w++;
        end
        if (w >= 300) check(sel ? "b_stall" : "a_stall", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic expect_res(input string tag, input logic src, input int sum, input int cnt);
        res_t r;
        int   w = 0;
        while (rq.size() == 0 && w < 300) begin
            @(posedge clk);
            w++;
        end
        if (rq.size() == 0) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        r = rq.pop_front();
        check({tag, "_src"}, 32'(r.src), 32'(src));
        check({tag, "_sum"}, 32'(r.sum), 32'(sum));
        check({tag, "_cnt"}, 32'(r.cnt), 32'(cnt));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_a_ready"},   32'(bus.a_ready),   32'd0);
        check({tag, "_b_ready"},   32'(bus.b_ready),   32'd0);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_out_sum"},   32'(bus.out_sum),   32'd0);
        check({tag, "_out_src"},   32'(bus.out_src),   32'd0);
        check({tag, "_out_count"}, 32'(bus.out_count), 32'd0);
        check({tag, "_busy"},      32'(busy),          32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int cyc;
        int stab_bad;
        int rdy_bad;

        rst = 1'b1;
        bus.a_valid = 1'b0; bus.a_data = '0; bus.a_last = 1'b0;
        bus.b_valid = 1'b0; bus.b_data = '0; bus.b_last = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;
        @(negedge clk);

        // Full-length frame of maximum operands, with latency from first valid
        fork
            begin
                for (int i = 0; i < 8; i++) drive(1'b0, 14'd16383, i == 7);
                bus.a_valid = 1'b0; bus.a_last = 1'b0;
            end
            begin
                cyc = 0;
                while (!bus.out_valid && cyc < 50) begin
                    @(posedge clk); #1;
                    cyc++;
                end
                check("single_latency", 32'(cyc), 32'd10);
            end
        join
        expect_res("single", 1'b0, 131064, 8);

        // Short frame from B
        @(negedge clk);
        drive(1'b1, 14'd5, 1'b0);
        drive(1'b1, 14'd7, 1'b0);
        drive(1'b1, 14'd9, 1'b1);
        bus.b_valid = 1'b0; bus.b_last = 1'b0;
        expect_res("short", 1'b1, 21, 3);

        // Ten beats with last only on the tenth: closes at 8, remainder is a new frame
        @(negedge clk);
        for (int i = 0; i < 10; i++) drive(1'b0, 14'd1, i == 9);
        bus.a_valid = 1'b0; bus.a_last = 1'b0;
        expect_res("trunc1", 1'b0, 8, 8);
        expect_res("trunc2", 1'b0, 2, 2);

        // Continuous contention from both requesters after a fresh reset
        @(negedge clk);
        do_reset();
        both_rdy = 0;
        fork
            begin
                drive(1'b0, 14'd3, 1'b1);
                drive(1'b0, 14'd4, 1'b1);
                bus.a_valid = 1'b0;
            end
            begin
                drive(1'b1, 14'd10, 1'b1);
                drive(1'b1, 14'd20, 1'b1);
                bus.b_valid = 1'b0;
            end
        join
        bus.a_last = 1'b0; bus.b_last = 1'b0;
        expect_res("cont0", 1'b0, 3, 1);
        expect_res("cont1", 1'b1, 10, 1);
        expect_res("cont2", 1'b0, 4, 1);
        expect_res("cont3", 1'b1, 20, 1);
        check("cont_both_ready", 32'(both_rdy), 32'd0);

        // Result held under backpressure
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        drive(1'b1, 14'd1, 1'b0);
        drive(1'b1, 14'd2, 1'b1);
        bus.b_valid = 1'b0; bus.b_last = 1'b0;
        cyc = 0;
        while (!bus.out_valid && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("bp_valid", 32'(bus.out_valid), 32'd1);
        stab_bad = 0;
        rdy_bad  = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.out_sum !== 17'd3 || bus.out_src !== 1'b1 ||
                bus.out_count !== 4'd2 || bus.out_valid !== 1'b1) stab_bad++;
            if (bus.a_ready || bus.b_ready) rdy_bad++;
        end
        check("bp_stable", 32'(stab_bad), 32'd0);
        check("bp_readies", 32'(rdy_bad), 32'd0);
        check("bp_queue_empty", 32'(rq.size()), 32'd0);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", 32'(bus.out_valid), 32'd0);
        check("bp_release_busy", 32'(busy), 32'd0);
        expect_res("bp", 1'b1, 3, 2);

        // Reset in the middle of a frame discards it
        @(negedge clk);
        for (int i = 0; i < 4; i++) drive(1'b0, 14'd100, 1'b0);
        rst = 1'b1;
        bus.a_valid = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst_no_result", 32'(rq.size()), 32'd0);
        drive(1'b0, 14'd5, 1'b0);
        drive(1'b0, 14'd6, 1'b1);
        bus.a_valid = 1'b0; bus.a_last = 1'b0;
        expect_res("post_rst", 1'b0, 11, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/adder_frame_scheduler.md
# adder_frame_scheduler

Frame-level scheduler that shares one accumulating 2-input adder between two requesters, each streaming frames of up to 2**LEVELS unsigned operands. Round-robin arbitration picks a requester, locks the adder to it for one frame, and serially sums the operands one per cycle. The block returns a full-precision sum tagged with its source and operand count. It is the low-area, time-multiplexed alternative to the fully parallel registered adder tree, for contexts where operand throughput is at most one per cycle.

## Interface

Parameters:
- ADDER_WIDTH, default 14: operand width in bits.
- LEVELS, default 3: log2 of the maximum operands per frame; max frame length N = 2**LEVELS.

Ports:
- clk  input  1  — single clock; all state updates on the rising edge.
- rst  input  1  — reset, asynchronous and active-high.
- a_valid  input  1  — requester A beat valid.
- a_ready  output  1  — requester A beat accepted when a_valid & a_ready.
- a_data  input  ADDER_WIDTH  — requester A operand, unsigned.
- a_last  input  1  — marks the final operand of A's frame.
- b_valid, b_ready, b_data, b_last — same as the A ports, for requester B.
- out_valid  output  1  — result available.
- out_ready  input  1  — result consumed when out_valid & out_ready.
- out_sum  output  ADDER_WIDTH+LEVELS  — frame sum.
- out_src  output  1  — 0 = A, 1 = B.
- out_count  output  LEVELS+1  — operands in the frame, range 1..N.
- busy  output  1  — high in any state other than IDLE.

## Operation

- States: IDLE, ARB, ACCUM, HOLD.
- IDLE:
  - Both readies low, out_valid low.
  - If a_valid | b_valid, go to ARB.
- ARB (one cycle):
  - Register the grant. If only one requester is valid, it wins.
  - If both are valid, the requester other than last_src wins.
  - last_src updates to the winner.
  - If neither is valid (a requester dropped valid), return to IDLE with no grant.
  - Clear the accumulator and count. Go to ACCUM.
- ACCUM:
  - Only the granted requester's ready is high; the other's ready stays low.
  - On each handshake: acc <= acc + zero-extended data; cnt <= cnt + 1.
  - The frame ends on the handshake where last = 1, or where cnt reaches N (count N including this beat), whichever comes first.
  - At frame end, load out_sum, out_src and out_count. Go to HOLD.
  - No handshake means no state change; a granted requester may stall indefinitely.
- Truncation at N:
  - If the N-th beat arrives with last = 0, the frame is still closed.
  - The next beat from that requester starts a new frame, which must win arbitration again.
- HOLD:
  - out_valid is high. Both readies are low.
  - out_sum, out_src and out_count are stable until out_ready.
  - On out_ready, go to IDLE.
- Arithmetic: unsigned. The accumulator is ADDER_WIDTH+LEVELS bits, so overflow is impossible within N operands.
- Reset (asynchronous, any state):
  - State = IDLE, last_src = 1 (so A wins the first tie).
  - Accumulator and count cleared.
  - The frame in progress is discarded; no partial result is emitted.
- Reset values of outputs: a_ready = 0, b_ready = 0, out_valid = 0, out_sum = 0, out_src = 0, out_count = 0, busy = 0.

## Timing

- All outputs are registered or decoded from state only. No combinational path from any valid or out_ready input to any output.
- For a frame of k beats with no stalls:
  - Request seen in IDLE at cycle t.
  - ARB at t+1.
  - Beats accepted at t+2 .. t+k+1.
  - out_valid high at t+k+2.
- With out_ready held high, HOLD lasts 1 cycle. IDLE follows, and the next ARB occurs 2 cycles after the HOLD cycle.
- Minimum frame period is k+3 cycles.
- A pending requester waits at most one full frame of the other requester, so no starvation.

## Test plan

- Single frame: A sends 8 × 16383 with a_last on beat 8 (ADDER_WIDTH=14, LEVELS=3). Required: out_sum = 131064, out_src = 0, out_count = 8, out_valid exactly 10 cycles after a_valid first rises.
- Short frame: B sends 5, 7, 9 with b_last on the 3rd beat. Required: out_sum = 21, out_src = 1, out_count = 3.
- Truncation: A holds a_valid for 10 beats of value 1, with a_last only on beat 10. Required: first result out_sum = 8, out_count = 8; second frame out_sum = 2, out_count = 2 after re-arbitration.
- Contention: A and B valid together continuously. Required: grants alternate A, B, A, B; the first result after reset is from A; b_ready stays 0 throughout any A frame.
- Backpressure: out_ready held low for 20 cycles in HOLD. Required: out_sum, out_src and out_count are stable and both readies stay 0; one handshake then returns the block to IDLE.
- Reset mid-frame: assert rst after 4 accepted beats of A. Required: all outputs are at reset values immediately; no result is emitted; the next frame sums only post-reset beats.
